// File: rtl/verifier_beta_pkg.sv
// Shared state encoding and field constants for the sequential beta evaluator.
`include "field_arith_defs.sv"

package verifier_beta_pkg;
    localparam int FW = `F_NBITS;
    localparam logic [FW-1:0] FIELD_P = `F_P;
    localparam logic [FW-1:0] ONE = {{(FW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DBL,
        ST_MULADD,
        ST_1M,
        ST_ADD,
        ST_MUL,
        ST_SCALE,
        ST_DONE
    } state_t;
endpackage

// File: rtl/field_adder.sv
// Modular adder: result (a + b) mod p one cycle after an enable pulse.
// Operands may be any F_NBITS value, not only reduced residues.
`include "field_arith_defs.sv"

module field_adder (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_en,
    input  logic [`F_NBITS-1:0] i_a,
    input  logic [`F_NBITS-1:0] i_b,
    output logic [`F_NBITS-1:0] o_sum,
    output logic                o_ready
);
    logic [`F_NBITS:0]   w_sum;
    logic [`F_NBITS-1:0] r_sum;
    logic                r_ready;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sum   <= '0;
            r_ready <= 1'b0;
        end else if (i_en) begin
            r_sum   <= `F_NBITS'(w_sum % {1'b0, `F_P});
            r_ready <= 1'b1;
        end
    end

    assign o_sum   = r_sum;
    assign o_ready = r_ready;
endmodule

// File: rtl/field_arith_defs.sv
// Prime-field constants shared by the field units and the beta sequencer.
// p = 65521 = 2^16 - 15; F_I folds a lost shift-out bit back in, F_Q_P2_MI turns ~S into 1 - S.
`ifndef FIELD_ARITH_DEFS_SV
`define FIELD_ARITH_DEFS_SV
`define F_NBITS 16
`define F_P 16'd65521
`define F_I 16'd15
`define F_Q_P2_MI 16'd65508
`endif

// File: rtl/field_multiplier.sv
// Modular multiplier: operands captured on the enable pulse, product mod p
// ready two cycles later; ready drops while an operation is pending.
`include "field_arith_defs.sv"

module field_multiplier (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_en,
    input  logic [`F_NBITS-1:0] i_a,
    input  logic [`F_NBITS-1:0] i_b,
    output logic [`F_NBITS-1:0] o_prod,
    output logic                o_ready
);
    localparam logic [2*`F_NBITS-1:0] P_WIDE = {{`F_NBITS{1'b0}}, `F_P};

    logic [`F_NBITS-1:0]   r_a;
    logic [`F_NBITS-1:0]   r_b;
    logic                  r_pend;
    logic [`F_NBITS-1:0]   r_prod;
    logic                  r_ready;
    logic [2*`F_NBITS-1:0] w_full;

    assign w_full = {{`F_NBITS{1'b0}}, r_a} * {{`F_NBITS{1'b0}}, r_b};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_a     <= '0;
            r_b     <= '0;
            r_pend  <= 1'b0;
            r_prod  <= '0;
            r_ready <= 1'b0;
        end else if (i_en) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_pend  <= 1'b1;
            r_ready <= 1'b0;
        end else if (r_pend) begin
            r_prod  <= `F_NBITS'(w_full % P_WIDE);
            r_pend  <= 1'b0;
            r_ready <= 1'b1;
        end
    end

    assign o_prod  = r_prod;
    assign o_ready = r_ready;
endmodule

// File: rtl/verifier_compute_beta_seq.sv
// Sequential beta(z, w) = prod (2wz + 1 - w - z) mod p over up to NCOORD pairs,
// sharing one field adder and one field multiplier, with zero early-out and optional scaling.
`include "field_arith_defs.sv"

module verifier_compute_beta_seq
    import verifier_beta_pkg::*;
#(
    parameter int NCOORD = 8,
    parameter int CW     = $clog2(NCOORD + 1)
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       start,
    input  logic                       restart,
    input  logic [CW-1:0]              ncoord,
    input  logic [`F_NBITS*NCOORD-1:0] w_vals,
    input  logic [`F_NBITS*NCOORD-1:0] z_vals,
    input  logic                       scale_en,
    input  logic [`F_NBITS-1:0]        scale_in,
    output logic                       busy,
    output logic                       done,
    output logic [`F_NBITS-1:0]        beta_out,
    output logic [CW-1:0]              coord_idx
);
    state_t          r_state;
    logic            r_pulse;
    logic            r_busy;
    logic            r_done;
    logic [FW-1:0]   r_acc;
    logic [CW-1:0]   r_idx;
    logic [CW-1:0]   r_neff;
    logic            r_scaleEn;
    logic [FW-1:0]   r_d;
    logic [FW-1:0]   r_s;
    logic [FW-1:0]   r_m;
    logic [FW-1:0]   r_n;
    logic [FW-1:0]   r_t;

    logic [CW-1:0]   w_neff;
    logic [CW-1:0]   w_idxNext;
    logic            w_lastIdx;
    state_t          w_finState;
    logic [FW-1:0]   w_w0;
    logic [FW-1:0]   w_wCur;
    logic [FW-1:0]   w_zCur;
    logic [FW-1:0]   w_wNext;
    logic            w_addEn;
    logic [FW-1:0]   w_addA;
    logic [FW-1:0]   w_addB;
    logic [FW-1:0]   w_addSum;
    logic            w_addReady;
    logic            w_mulEn;
    logic [FW-1:0]   w_mulA;
    logic [FW-1:0]   w_mulB;
    logic [FW-1:0]   w_mulProd;
    logic            w_mulReady;
    logic            w_rstn;

    // A set MSB means w<<1 overflows, so the doubling needs a reducing add.
    function automatic state_t coordState(input logic msb);
        return msb ? ST_DBL : ST_MULADD;
    endfunction

    assign w_neff     = (ncoord > CW'(NCOORD)) ? CW'(NCOORD) : ncoord;
    assign w_idxNext  = r_idx + CW'(1);
    assign w_lastIdx  = (r_idx == r_neff - CW'(1));
    assign w_finState = r_scaleEn ? ST_SCALE : ST_DONE;
    assign w_w0       = w_vals[FW-1:0];
    assign w_rstn     = ~rstb;

    always_comb begin
        w_wCur  = '0;
        w_zCur  = '0;
        w_wNext = '0;
        for (int i = 0; i < NCOORD; i++) begin
            if (CW'(i) == r_idx) begin
                w_wCur = w_vals[i*FW +: FW];
                w_zCur = z_vals[i*FW +: FW];
            end
            if (CW'(i) == w_idxNext) begin
                w_wNext = w_vals[i*FW +: FW];
            end
        end
    end

    // Operand steering for the shared units; enables fire only on the first cycle of a state.
    always_comb begin
        w_addEn = 1'b0;
        w_addA  = '0;
        w_addB  = '0;
        w_mulEn = 1'b0;
        w_mulA  = '0;
        w_mulB  = '0;
        case (r_state)
            ST_DBL: begin
                w_addEn = r_pulse;
                w_addA  = {w_wCur[FW-2:0], 1'b0};
                w_addB  = `F_I;
            end
            ST_MULADD: begin
                w_addEn = r_pulse;
                w_addA  = w_wCur;
                w_addB  = w_zCur;
                w_mulEn = r_pulse;
                w_mulA  = w_zCur;
                w_mulB  = r_d;
            end
            ST_1M: begin
                w_addEn = r_pulse;
                w_addA  = ~r_s;
                w_addB  = `F_Q_P2_MI;
            end
            ST_ADD: begin
                w_addEn = r_pulse;
                w_addA  = r_m;
                w_addB  = r_n;
            end
            ST_MUL: begin
                w_mulEn = r_pulse;
                w_mulA  = r_acc;
                w_mulB  = r_t;
            end
            ST_SCALE: begin
                w_mulEn = r_pulse;
                w_mulA  = r_acc;
                w_mulB  = scale_in;
            end
            default: begin
            end
        endcase
    end

    field_adder u_adder (
        .clk     (clk),
        .rstn    (w_rstn),
        .i_en    (w_addEn),
        .i_a     (w_addA),
        .i_b     (w_addB),
        .o_sum   (w_addSum),
        .o_ready (w_addReady)
    );

    field_multiplier u_mul (
        .clk     (clk),
        .rstn    (w_rstn),
        .i_en    (w_mulEn),
        .i_a     (w_mulA),
        .i_b     (w_mulB),
        .o_prod  (w_mulProd),
        .o_ready (w_mulReady)
    );

    // Unit ready is only trusted after the pulse cycle, since it may still reflect the previous op.
    always_ff @(posedge clk) begin
        if (rstb) begin
            r_state   <= ST_IDLE;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_neff    <= '0;
            r_scaleEn <= 1'b0;
            r_d       <= '0;
            r_s       <= '0;
            r_m       <= '0;
            r_n       <= '0;
            r_t       <= '0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy    <= 1'b1;
                        r_idx     <= '0;
                        r_neff    <= w_neff;
                        r_scaleEn <= scale_en;
                        r_pulse   <= 1'b1;
                        r_d       <= {w_w0[FW-2:0], 1'b0};
                        if (restart) begin
                            r_acc <= ONE;
                        end
                        if (w_neff == '0) begin
                            r_state <= scale_en ? ST_SCALE : ST_DONE;
                        end else begin
                            r_state <= coordState(w_w0[FW-1]);
                        end
                    end
                end
                ST_DBL: begin
                    if (!r_pulse && w_addReady) begin
                        r_d     <= w_addSum;
                        r_state <= ST_MULADD;
                        r_pulse <= 1'b1;
                    end
                end
                ST_MULADD: begin
                    if (!r_pulse && w_addReady) begin
                        r_s     <= w_addSum;
                        r_state <= ST_1M;
                        r_pulse <= 1'b1;
                    end
                end
                ST_1M: begin
                    if (!r_pulse && w_addReady && w_mulReady) begin
                        r_n     <= w_addSum;
                        r_m     <= w_mulProd;
                        r_state <= ST_ADD;
                        r_pulse <= 1'b1;
                    end
                end
                ST_ADD: begin
                    if (!r_pulse && w_addReady) begin
                        if (w_addSum == '0) begin
                            r_acc   <= '0;
                            r_state <= ST_DONE;
                        end else if (r_acc == ONE) begin
                            r_acc   <= w_addSum;
                            r_pulse <= 1'b1;
                            if (w_lastIdx) begin
                                r_state <= w_finState;
                            end else begin
                                r_idx   <= w_idxNext;
                                r_d     <= {w_wNext[FW-2:0], 1'b0};
                                r_state <= coordState(w_wNext[FW-1]);
                            end
                        end else begin
                            r_t     <= w_addSum;
                            r_state <= ST_MUL;
                            r_pulse <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (!r_pulse && w_mulReady) begin
                        r_acc   <= w_mulProd;
                        r_pulse <= 1'b1;
                        if (w_lastIdx) begin
                            r_state <= w_finState;
                        end else begin
                            r_idx   <= w_idxNext;
                            r_d     <= {w_wNext[FW-2:0], 1'b0};
                            r_state <= coordState(w_wNext[FW-1]);
                        end
                    end
                end
                ST_SCALE: begin
                    if (!r_pulse && w_mulReady) begin
                        r_acc   <= w_mulProd;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Two cycles here: one to arm, one with done visible while busy is still high.
                    if (!r_done) begin
                        r_done <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign beta_out  = r_acc;
    assign coord_idx = r_idx;
endmodule
